// File: rtl/add7_feeder.sv
// add7_feeder: front end for the 7-input adder kernel.
// Collects seven operand words from a valid/ready stream, pulses k_start
// for one cycle, waits for k_done under a watchdog and returns the kernel
// result (or 0 with m_timeout=1) on a valid/ready output stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | accepting operand words into slots 0..6
//   START   | one-cycle k_start pulse, stale k_done ignored
//   WAIT    | waiting for k_done, watchdog counting
//   OUT     | result presented on m_*, held until m_ready

module add7_feeder #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        k_start,
    output logic [31:0] k_a,
    output logic [31:0] k_b,
    output logic [31:0] k_c,
    output logic [31:0] k_d,
    output logic [31:0] k_e,
    output logic [31:0] k_f,
    output logic [31:0] k_g,
    input  logic        k_done,
    input  logic [31:0] k_result,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_timeout,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        OUT     = 2'd3
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  idx;
    logic [15:0] wdog;

    // Sequencer: framing, kernel handshake, watchdog and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= 3'd0;
            wdog      <= 16'd0;
            s_ready   <= 1'b0;
            k_start   <= 1'b0;
            k_a       <= 32'd0;
            k_b       <= 32'd0;
            k_c       <= 32'd0;
            k_d       <= 32'd0;
            k_e       <= 32'd0;
            k_f       <= 32'd0;
            k_g       <= 32'd0;
            m_valid   <= 1'b0;
            m_data    <= 32'd0;
            m_timeout <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            case (state)
                COLLECT: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        case (idx)
                            3'd0:    k_a <= s_data;
                            3'd1:    k_b <= s_data;
                            3'd2:    k_c <= s_data;
                            3'd3:    k_d <= s_data;
                            3'd4:    k_e <= s_data;
                            3'd5:    k_f <= s_data;
                            3'd6:    k_g <= s_data;
                            default: ;
                        endcase
                        if (idx == 3'd6) begin
                            // Seventh word completes the frame; s_last is irrelevant here.
                            idx     <= 3'd0;
                            s_ready <= 1'b0;
                            k_start <= 1'b1;
                            state   <= START;
                        end else if (s_last) begin
                            // Short frame: throw it away and start over at slot 0.
                            idx <= 3'd0;
                            if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                START: begin
                    // k_done still reflects the previous run here, so it is not looked at.
                    k_start <= 1'b0;
                    wdog    <= 16'd0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (k_done) begin
                        m_data    <= k_result;
                        m_timeout <= 1'b0;
                        m_valid   <= 1'b1;
                        state     <= OUT;
                    end else if (wdog == WDOG_LAST) begin
                        m_data    <= 32'd0;
                        m_timeout <= 1'b1;
                        m_valid   <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add7_feeder.sv
// Bench for add7_feeder: behavioural kernel, directed frames, scoreboard.
module tb_add7_feeder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [31:0] s_data;
    logic        k_start, k_done;
    logic [31:0] k_a, k_b, k_c, k_d, k_e, k_f, k_g, k_result;
    logic        m_valid, m_ready, m_timeout;
    logic [31:0] m_data;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    add7_feeder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .k_start(k_start),
        .k_a(k_a), .k_b(k_b), .k_c(k_c), .k_d(k_d), .k_e(k_e), .k_f(k_f), .k_g(k_g),
        .k_done(k_done), .k_result(k_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_timeout(m_timeout),
        .drop_cnt(drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    int starts   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Kernel model: no reset, done stays high after a run, result changes at done.
    int          kern_lat    = 8;
    bit          kernel_dead = 1'b0;
    logic        kdone_r = 1'b1;
    logic [31:0] kres    = 32'hDEAD0000;
    logic [31:0] ksum    = 32'd0;
    int          kcnt    = 0;

    always @(posedge clk) begin
        if (k_start) begin
            kdone_r <= 1'b0;
            kcnt    <= kern_lat;
            ksum    <= k_a + k_b + k_c + k_d + k_e + k_f + k_g;
        end else if (kcnt == 1) begin
            kdone_r <= 1'b1;
            kres    <= ksum;
            kcnt    <= 0;
        end else if (kcnt > 1) begin
            kcnt <= kcnt - 1;
        end
    end

    assign k_done   = kdone_r && !kernel_dead;
    assign k_result = kres;

    typedef struct {
        logic [31:0] data;
        logic        to;
        int          lat;
    } exp_t;

    typedef struct {
        logic [6:0][31:0] w;
    } ops_t;

    exp_t exp_q[$];
    ops_t ops_q[$];

    // Monitor: operand check on k_start, latency/hold/result check on m_*.
    logic        prev_mv = 1'b0;
    logic [31:0] held_d  = 32'd0;
    logic        held_to = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (k_start) begin
                starts++;
                if (ops_q.size() == 0) begin
                    check("unexpected_k_start", 32'(k_start), 32'd0);
                end else begin
                    ops_t o;
                    o = ops_q.pop_front();
                    check("k_a", k_a, o.w[0]);
                    check("k_b", k_b, o.w[1]);
                    check("k_c", k_c, o.w[2]);
                    check("k_d", k_d, o.w[3]);
                    check("k_e", k_e, o.w[4]);
                    check("k_f", k_f, o.w[5]);
                    check("k_g", k_g, o.w[6]);
                end
            end
            if (m_valid && !prev_mv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_m_valid", 32'(m_valid), 32'd0);
                end else begin
                    check("latency", 32'(cyc - accept_cyc), 32'(exp_q[0].lat));
                end
                held_d  = m_data;
                held_to = m_timeout;
            end else if (m_valid) begin
                check("hold_m_data", m_data, held_d);
                check("hold_m_timeout", 32'(m_timeout), 32'(held_to));
            end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_data", m_data, e.data);
                check("m_timeout", 32'(m_timeout), 32'(e.to));
            end
        end
        prev_mv = m_valid;
    end

    function automatic logic [6:0][31:0] fill(input logic [31:0] v);
        logic [6:0][31:0] w;
        for (int i = 0; i < 7; i++) w[i] = v;
        return w;
    endfunction

    function automatic logic [6:0][31:0] seq(input logic [31:0] base);
        logic [6:0][31:0] w;
        for (int i = 0; i < 7; i++) w[i] = base + 32'(i);
        return w;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last);
        int   n;
        logic rdy;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 200);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("accept", 32'(rdy), 32'd1);
    endtask

    task automatic send_frame(input logic [6:0][31:0] w, input logic last6,
                              input logic [31:0] exp_d, input logic exp_to, input int lat);
        exp_t e;
        ops_t o;
        e.data = exp_d; e.to = exp_to; e.lat = lat;
        o.w = w;
        exp_q.push_back(e);
        ops_q.push_back(o);
        for (int i = 0; i < 7; i++) send_word(w[i], (i == 6) ? last6 : 1'b0);
        accept_cyc = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_s_ready",   32'(s_ready),   32'd0);
        check("rst_k_start",   32'(k_start),   32'd0);
        check("rst_k_a", k_a, 32'd0);
        check("rst_k_b", k_b, 32'd0);
        check("rst_k_c", k_c, 32'd0);
        check("rst_k_d", k_d, 32'd0);
        check("rst_k_e", k_e, 32'd0);
        check("rst_k_f", k_f, 32'd0);
        check("rst_k_g", k_g, 32'd0);
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_m_data",    m_data,         32'd0);
        check("rst_m_timeout", 32'(m_timeout), 32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s_ready_after_reset", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        // Normal frame 1..7 and wrap-around frame
        send_frame(seq(32'd1), 1'b1, 32'd28, 1'b0, 10);
        wait_drain();
        send_frame(fill(32'hFFFFFFFF), 1'b1, 32'hFFFFFFF9, 1'b0, 10);
        wait_drain();

        // Early s_last discards a 3-word frame
        send_word(32'd5, 1'b0);
        send_word(32'd6, 1'b0);
        send_word(32'd7, 1'b1);
        @(negedge clk);
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
        @(posedge clk); #1;
        send_frame(fill(32'd10), 1'b1, 32'd70, 1'b0, 10);
        wait_drain();
        check("starts_after_drop", 32'(starts), 32'd3);

        // Backpressure on the result, then a second frame with stale done high
        m_ready = 1'b0;
        send_frame(seq(32'd100), 1'b1, 32'd721, 1'b0, 10);
        begin
            int n;
            n = 0;
            while (!m_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("bp_m_valid_seen", 32'(m_valid), 32'd1);
        end
        repeat (20) @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_frame(fill(32'd1), 1'b1, 32'd7, 1'b0, 10);
        wait_drain();

        // Watchdog with done tied low: 1 START + 16 WAIT cycles
        kernel_dead = 1'b1;
        send_frame(fill(32'd3), 1'b1, 32'd0, 1'b1, 17);
        wait_drain();
        kernel_dead = 1'b0;

        // Done on the expiry cycle wins; one cycle later it is a timeout
        kern_lat = 15;
        send_frame(fill(32'd4), 1'b1, 32'd28, 1'b0, 17);
        wait_drain();
        kern_lat = 16;
        send_frame(fill(32'd5), 1'b1, 32'd0, 1'b1, 17);
        wait_drain();
        kern_lat = 8;
        repeat (4) @(posedge clk);
        #1;

        // Seventh word without s_last still ends the frame
        send_frame(seq(32'd11), 1'b0, 32'd98, 1'b0, 10);
        wait_drain();

        // One-word frame discarded; its word still lands in slot 0
        send_word(32'd9, 1'b1);
        @(negedge clk);
        check("drop_cnt_2", 32'(drop_cnt), 32'd2);
        check("k_a_after_drop", k_a, 32'd9);
        @(posedge clk); #1;
        for (int i = 0; i < 255; i++) send_word(32'(i), 1'b1);
        @(negedge clk);
        check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        @(posedge clk); #1;

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) send_word(32'd2, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(fill(32'd2), 1'b1, 32'd14, 1'b0, 10);
        wait_drain();

        check("total_starts", 32'(starts), 32'd10);
        check("ops_queue_empty", 32'(ops_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add7_feeder.md
# add7_feeder

Upstream front end for the 7-input adder kernel. It collects seven 32-bit operands from a valid/ready stream and loads them into the kernel with a one-cycle start pulse. It then waits for the kernel's done flag, with a watchdog, and returns the sum on a valid/ready output stream. It owns all framing and flow control, so the kernel only ever sees clean single-cycle start pulses.

## Interface

- TIMEOUT_CYCLES, 64, WAIT cycles allowed before a watchdog abort (≥ 16; 16 ≤ value < 2^16)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  operand word valid
- s_ready  out  1  feeder accepts operand word
- s_data  in  32  operand word
- s_last  in  1  frame end marker
- k_start  out  1  one-cycle load pulse to kernel r_enable
- k_a..k_g  out  32 each  operand buffer to kernel init_a..init_g; word 0 → k_a … word 6 → k_g
- k_done  in  1  kernel w_enable
- k_result  in  32  kernel result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  32  sum, or 0 on timeout
- m_timeout  out  1  qualifies m_data: 1 = watchdog abort
- drop_cnt  out  8  saturating count of discarded frames

## Operation

- States: COLLECT, START, WAIT, OUT. Reset enters COLLECT with idx=0.
- COLLECT:
  - s_ready=1. Each s_valid&&s_ready handshake writes s_data into operand slot idx.
  - If s_last=1 and idx<6, the frame is discarded: idx→0, drop_cnt increments (saturates at 255), state stays COLLECT.
  - If idx=6, s_last is ignored and the state moves to START. idx→0.
- START:
  - k_start=1 for exactly this cycle. s_ready=0.
  - k_done is ignored here because the kernel's done flag from the previous run is still high.
  - Next state is always WAIT, with wdog cleared to 0.
- WAIT:
  - If k_done=1, capture k_result into m_data, set m_timeout=0, go to OUT.
  - Else if wdog=TIMEOUT_CYCLES-1, set m_data=0 and m_timeout=1, go to OUT.
  - Else wdog increments.
- OUT:
  - m_valid=1. m_data and m_timeout are held stable until m_ready.
  - On m_valid&&m_ready, go to COLLECT.
- k_a..k_g change only on COLLECT handshakes. They are stable through START and WAIT.
- No arithmetic in this block. The sum is whatever the kernel returns (mod 2^32).

## Timing

- All outputs are registered.
- Reset values: s_ready=0 while rst_n=0, then 1 from the first cycle in COLLECT. k_start=0, k_a..k_g=0, m_valid=0, m_data=0, m_timeout=0, drop_cnt=0.
- Accept rate in COLLECT: one word per cycle.
- Latency with the current kernel:
  - 7th word accepted at edge T.
  - k_start is high from T to T+1.
  - Kernel w_enable rises after T+9. The feeder samples it at T+10.
  - m_valid=1 after edge T+10.
- Back-to-back frames: after the result handshake, the next word can be accepted in the following cycle.
- Boundary cases:
  - A k_done pulse arriving on the same cycle that the watchdog expires counts as done (done has priority).
  - s_valid with s_last on word 6 is a normal frame end.
  - s_last arriving on word 0 discards a one-word frame.
- Reset mid-operation:
  - Asserting rst_n=0 in any state returns to COLLECT and discards any partial frame or pending result. k_start drops immediately.
  - The kernel has no reset. Its stale k_done is harmless because k_done is sampled only in WAIT.

## Test plan

- Normal frame:
  - Stimulus: words 1,2,3,4,5,6,7 with s_last on the 7th, m_ready=1.
  - Response: one k_start pulse; k_a=1 … k_g=7; m_data=28 and m_timeout=0 ten cycles after the 7th accept.
- Wrap:
  - Stimulus: seven words of 0xFFFFFFFF.
  - Response: m_data=0xFFFFFFF9.
- Early s_last:
  - Stimulus: 3 words with s_last on the 3rd, then a good frame of all-10 words.
  - Response: drop_cnt=1; a single k_start; m_data=70.
- Backpressure and stale done:
  - Stimulus: hold m_ready=0 for 20 cycles after m_valid, then send a second frame of all-1 words.
  - Response: m_data held at its value until the handshake; the second result is 7, not the first frame's result.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16 with k_done tied low.
  - Response: after 16 WAIT cycles, m_valid=1, m_timeout=1, m_data=0.
- Reset mid-frame:
  - Stimulus: rst_n low after 4 words, then release.
  - Response: all outputs return to their reset values; a following 7-word frame of all-2 words returns 14.
